// File: rtl/riscv_trace_queue.sv
// Retirement trace queue: buffers retired PC/opcode pairs with a sequence number
// for a trace consumer, dropping (and flagging the gap) when the consumer falls behind.
module riscv_trace_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8,
  parameter int BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ret_vld,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [31:0]              ret_op,
  output logic                     trc_vld,
  input  logic                     trc_rdy,
  output logic [XLEN-1:0]          trc_pc,
  output logic [31:0]              trc_op,
  output logic [15:0]              trc_seq,
  output logic                     trc_gap,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [15:0]              drp_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] BUBBLE_OP = 32'h0000_4033;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     op;
    logic [15:0]     seq;
    logic            gap;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [15:0]   seq;
  logic [15:0]   drp;
  logic          gap_pending;

  logic is_bubble, accept, full, pop, push, drop;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    is_bubble = (BUBBLE != 0) && (ret_op == BUBBLE_OP);
    accept    = ret_vld && !is_bubble && !clr;
    full      = (occ == CW'(DEPTH));
    pop       = (occ != '0) && trc_rdy && !clr;
    push      = accept && (!full || pop);
    drop      = accept && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      seq         <= '0;
      drp         <= '0;
      gap_pending <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      seq         <= '0;
      drp         <= '0;
      gap_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // Dropped retirements still consume a sequence number so the gap is measurable.
      if (accept) seq <= seq + 1'b1;
      if (push)
        gap_pending <= 1'b0;
      else if (drop)
        gap_pending <= 1'b1;
      if (drop && drp != 16'hFFFF) drp <= drp + 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked by occ and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: ret_pc, op: ret_op, seq: seq, gap: gap_pending};
  end

  always_comb begin
    head    = mem[rd_ptr];
    trc_vld = (occ != '0);
    trc_pc  = trc_vld ? head.pc  : '0;
    trc_op  = trc_vld ? head.op  : '0;
    trc_seq = trc_vld ? head.seq : '0;
    trc_gap = trc_vld ? head.gap : 1'b0;
  end

  assign cnt     = occ;
  assign drp_cnt = drp;

endmodule
